id_ex_stage: RTL and testbench

//  Decode-to-execute pipeline stage that sits directly upstream of the ALU.

---
 rtl/rv_pipe_pkg.sv | 33 +++
 rtl/pipe_skid_buf.sv | 75 +++++++
 rtl/id_ex_stage.sv | 115 +++++++++++
 tb/tb_id_ex_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the ID/EX pipeline stage: datapath widths,
// ALU opcodes and the decoded-instruction payload carried through the skid buffer.
package rv_pipe_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 6;
    localparam int REG_AW = 5;

    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD    = 6'b000000,
        ALU_SLL    = 6'b000001,
        ALU_SLT    = 6'b000010,
        ALU_SLTU   = 6'b000011,
        ALU_BEQ    = 6'b010000,
        ALU_PASS_A = 6'b111111
    } alu_op_e;

    // alu_ctrl is a raw code so that any value from decode passes through untouched
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [CTRL_W-1:0] alu_ctrl;
        logic              branch_op;
        logic              alu_src_b;
        logic              reg_write;
    } id_ex_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry (head + skid) valid/ready buffer with flush. Upstream ready is
// registered (!skid_valid), so there is no combinational path from out_ready to in_ready.
module pipe_skid_buf #(
    parameter type T = logic [7:0]
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    input  logic flush,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    // Handshake: a beat transfers on a rising edge where valid and ready are both high;
    // valid must not depend on ready, and a flush discards everything, including the
    // beat offered in the same cycle.
    T     head_q, head_d;
    T     skid_q, skid_d;
    logic head_v_q, head_v_d;
    logic skid_v_q, skid_v_d;
    logic push, pop;

    assign in_ready  = !skid_v_q;
    assign out_valid = head_v_q;
    assign out_data  = head_q;

    always_comb begin
        head_d   = head_q;
        skid_d   = skid_q;
        head_v_d = head_v_q;
        skid_v_d = skid_v_q;
        push     = in_valid && !skid_v_q;
        pop      = head_v_q && out_ready;
        if (flush) begin
            head_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (pop) begin
            // push is impossible while the skid is occupied
            if (skid_v_q) begin
                head_d   = skid_q;
                skid_v_d = 1'b0;
            end else if (push) begin
                head_d = in_data;
            end else begin
                head_v_d = 1'b0;
            end
        end else if (push) begin
            if (!head_v_q) begin
                head_d   = in_data;
                head_v_d = 1'b1;
            end else begin
                skid_d   = in_data;
                skid_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q   <= '0;
            skid_q   <= '0;
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            skid_q   <= skid_d;
            head_v_q <= head_v_d;
            skid_v_q <= skid_v_d;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: skid-buffered decoded instruction, operand selection with
// optional EX/MEM and MEM/WB forwarding (enabled by defining ID_EX_FWD_EN), stall counter.
import rv_pipe_pkg::*;

module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [CTRL_W-1:0] in_alu_ctrl,
    input  logic              in_branch_op,
    input  logic              in_alu_src_b,
    input  logic              in_reg_write,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [XLEN-1:0]   memwb_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   operand_A,
    output logic [XLEN-1:0]   operand_B,
    output logic [CTRL_W-1:0] ALU_Control,
    output logic              branch_op,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write,
    output logic [CNT_W-1:0]  stall_cycles
);

    id_ex_payload_t in_pl, head;
    logic [XLEN-1:0]  fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        in_pl           = '0;
        in_pl.pc        = in_pc;
        in_pl.rs1_data  = in_rs1_data;
        in_pl.rs2_data  = in_rs2_data;
        in_pl.imm       = in_imm;
        in_pl.rs1       = in_rs1;
        in_pl.rs2       = in_rs2;
        in_pl.rd        = in_rd;
        in_pl.alu_ctrl  = in_alu_ctrl;
        in_pl.branch_op = in_branch_op;
        in_pl.alu_src_b = in_alu_src_b;
        in_pl.reg_write = in_reg_write;
    end

    pipe_skid_buf #(.T(id_ex_payload_t)) u_buf (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_pl),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (head)
    );

`ifdef ID_EX_FWD_EN
    // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded
    function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] rs,
                                            input logic [XLEN-1:0]   d);
        if (exmem_reg_write && exmem_rd == rs && rs != '0)
            return exmem_result;
        else if (memwb_reg_write && memwb_rd == rs && rs != '0)
            return memwb_result;
        else
            return d;
    endfunction

    assign fwd_a = fwd(head.rs1, head.rs1_data);
    assign fwd_b = fwd(head.rs2, head.rs2_data);
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result, head.rs1, head.rs2};
    assign fwd_a = head.rs1_data;
    assign fwd_b = head.rs2_data;
`endif

    assign operand_A     = fwd_a;
    assign operand_B     = head.alu_src_b ? head.imm : fwd_b;
    assign ALU_Control   = head.alu_ctrl;
    assign branch_op     = head.branch_op;
    assign out_pc        = head.pc;
    assign out_rd        = head.rd;
    assign out_reg_write = head.reg_write;
    assign stall_cycles  = stall_q;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && stall_q != '1)
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) stall_q <= '0;
        else        stall_q <= stall_d;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; forwarding expectations follow ID_EX_FWD_EN.
module tb_id_ex_stage;
    import rv_pipe_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic [XLEN-1:0]   in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [REG_AW-1:0] in_rs1, in_rs2, in_rd;
    logic [CTRL_W-1:0] in_alu_ctrl;
    logic              in_branch_op, in_alu_src_b, in_reg_write;
    logic              flush;
    logic              exmem_reg_write, memwb_reg_write;
    logic [REG_AW-1:0] exmem_rd, memwb_rd;
    logic [XLEN-1:0]   exmem_result, memwb_result;
    logic              out_valid, out_ready;
    logic [XLEN-1:0]   operand_A, operand_B, out_pc;
    logic [CTRL_W-1:0] ALU_Control;
    logic              branch_op, out_reg_write;
    logic [REG_AW-1:0] out_rd;
    logic [15:0]       stall_cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    id_ex_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_ctrl(in_alu_ctrl),
        .in_branch_op(in_branch_op), .in_alu_src_b(in_alu_src_b), .in_reg_write(in_reg_write),
        .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand_A(operand_A), .operand_B(operand_B), .ALU_Control(ALU_Control),
        .branch_op(branch_op), .out_pc(out_pc), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .stall_cycles(stall_cycles)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_alu_ctrl = '0;
        in_branch_op = 0; in_alu_src_b = 0; in_reg_write = 0; flush = 0;
        exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic drive_item(input logic [XLEN-1:0] pc, input logic [REG_AW-1:0] rs1,
                              input logic [REG_AW-1:0] rs2, input logic [REG_AW-1:0] rd,
                              input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                              input logic [XLEN-1:0] imm, input logic [CTRL_W-1:0] ctrl,
                              input logic br, input logic srcb, input logic rw);
        in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_alu_ctrl = ctrl;
        in_branch_op = br; in_alu_src_b = srcb; in_reg_write = rw;
    endtask

    task automatic do_reset();
        reset = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 0;
        reset = 0;
        #3;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
        checks++; if (ALU_Control !== 6'b000000) begin failures++; $display("FAIL reset_alu_ctrl got=%0h exp=0", ALU_Control); end
        checks++; if (branch_op !== 1'b0) begin failures++; $display("FAIL reset_branch_op got=%0h exp=0", branch_op); end
        checks++; if (stall_cycles !== 16'h0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall_cycles); end
        @(negedge clock);
        reset = 1;
    endtask

    task automatic test_basic();
        out_ready = 1;
        drive_item(32'h100, 5'd1, 5'd2, 5'd7, 32'd4, 32'd5, 32'd0, ALU_ADD, 1'b1, 1'b0, 1'b1);
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%0h exp=1", out_valid); end
        checks++; if (operand_A !== 32'd4) begin failures++; $display("FAIL basic_opA got=%0h exp=4", operand_A); end
        checks++; if (operand_B !== 32'd5) begin failures++; $display("FAIL basic_opB got=%0h exp=5", operand_B); end
        checks++; if (ALU_Control !== 6'b000000) begin failures++; $display("FAIL basic_ctrl got=%0h exp=0", ALU_Control); end
        checks++; if (branch_op !== 1'b1 || out_rd !== 5'd7 || out_reg_write !== 1'b1 || out_pc !== 32'h100)
            begin failures++; $display("FAIL basic_fields got br=%0h rd=%0d rw=%0h pc=%0h exp br=1 rd=7 rw=1 pc=100", branch_op, out_rd, out_reg_write, out_pc); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%0h exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] exp_q[$];
        logic [XLEN-1:0] got_q[$];
        logic acc;
        out_ready = 0;
        exp_q = '{32'h200, 32'h204, 32'h208};
        drive_item(32'h200, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'h0, ALU_SLL, 1'b0, 1'b0, 1'b1);
        step();
        drive_item(32'h204, 5'd1, 5'd2, 5'd3, 32'hC, 32'hD, 32'h0, ALU_SLT, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_in_ready got=%0h exp=0", in_ready); end
        checks++; if (out_pc !== 32'h200 || operand_A !== 32'hA) begin failures++; $display("FAIL b2b_head got pc=%0h a=%0h exp pc=200 a=a", out_pc, operand_A); end
        drive_item(32'h208, 5'd1, 5'd2, 5'd3, 32'hE, 32'hF, 32'h0, ALU_BEQ, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (in_ready !== 1'b0 || out_pc !== 32'h200) begin failures++; $display("FAIL b2b_hold got rdy=%0h pc=%0h exp rdy=0 pc=200", in_ready, out_pc); end
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) got_q.push_back(out_pc);
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 0;
        end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_order[%0d] got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_flush();
        out_ready = 0;
        drive_item(32'h300, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b1);
        step();
        drive_item(32'h304, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b1);
        step();
        flush = 1;
        drive_item(32'h308, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b1);
        step();
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_full_valid got=%0h exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_full_ready got=%0h exp=1", in_ready); end
        drive_item(32'h310, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b1);
        step();
        flush = 1; out_ready = 1;
        drive_item(32'h314, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b1);
        step();
        flush = 0; in_valid = 0; out_ready = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_accept_dropped got=%0h exp=0", out_valid); end
        drive_item(32'h320, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b1);
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h320) begin failures++; $display("FAIL flush_after got v=%0h pc=%0h exp v=1 pc=320", out_valid, out_pc); end
        out_ready = 1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_residue got=%0h exp=0", out_valid); end
    endtask

    task automatic test_forwarding();
        logic [XLEN-1:0] exp_a, exp_b;
        out_ready = 0;
        drive_item(32'h400, 5'd3, 5'd3, 5'd9, 32'h11, 32'h22, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b1);
        step();
        in_valid = 0;
        exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'hFFFFFFFF;
        memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'd7;
        #1;
`ifdef ID_EX_FWD_EN
        exp_a = 32'hFFFFFFFF; exp_b = 32'hFFFFFFFF;
`else
        exp_a = 32'h11; exp_b = 32'h22;
`endif
        checks++; if (operand_A !== exp_a) begin failures++; $display("FAIL fwd_exmem_a got=%0h exp=%0h", operand_A, exp_a); end
        checks++; if (operand_B !== exp_b) begin failures++; $display("FAIL fwd_exmem_b got=%0h exp=%0h", operand_B, exp_b); end
        exmem_reg_write = 0;
        #1;
`ifdef ID_EX_FWD_EN
        exp_a = 32'd7;
`else
        exp_a = 32'h11;
`endif
        checks++; if (operand_A !== exp_a) begin failures++; $display("FAIL fwd_memwb_a got=%0h exp=%0h", operand_A, exp_a); end
        memwb_rd = 5'd4;
        #1;
        checks++; if (operand_A !== 32'h11) begin failures++; $display("FAIL fwd_nomatch_a got=%0h exp=11", operand_A); end
        flush = 1;
        step();
        flush = 0;
        drive_item(32'h404, 5'd0, 5'd0, 5'd9, 32'h55, 32'h66, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b1);
        step();
        in_valid = 0;
        exmem_reg_write = 1; exmem_rd = 5'd0; memwb_reg_write = 1; memwb_rd = 5'd0;
        #1;
        checks++; if (operand_A !== 32'h55) begin failures++; $display("FAIL fwd_x0_a got=%0h exp=55", operand_A); end
        checks++; if (operand_B !== 32'h66) begin failures++; $display("FAIL fwd_x0_b got=%0h exp=66", operand_B); end
        flush = 1;
        step();
        idle_inputs();
    endtask

    task automatic test_imm_and_stall();
        do_reset();
        out_ready = 0;
        drive_item(32'h500, 5'd1, 5'd2, 5'd3, 32'h1, 32'h99, 32'hFFFFFFFB, ALU_SLTU, 1'b0, 1'b1, 1'b1);
        step();
        in_valid = 0;
        checks++; if (operand_B !== 32'hFFFFFFFB) begin failures++; $display("FAIL imm_opB got=%0h exp=fffffffb", operand_B); end
        checks++; if (ALU_Control !== 6'b000011) begin failures++; $display("FAIL imm_ctrl got=%0h exp=3", ALU_Control); end
        checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL stall_start got=%0d exp=0", stall_cycles); end
        repeat (10) step();
        checks++; if (stall_cycles !== 16'd10) begin failures++; $display("FAIL stall_ten got=%0d exp=10", stall_cycles); end
        repeat (69990) step();
        checks++; if (stall_cycles !== 16'hFFFF) begin failures++; $display("FAIL stall_saturate got=%0h exp=ffff", stall_cycles); end
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        drive_item(32'h600, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, ALU_PASS_A, 1'b1, 1'b0, 1'b1);
        step();
        drive_item(32'h604, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, ALU_PASS_A, 1'b1, 1'b0, 1'b1);
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL areset_pre got v=%0h rdy=%0h exp v=1 rdy=0", out_valid, in_ready); end
        #2;
        reset = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%0h exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL areset_ready got=%0h exp=1", in_ready); end
        checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL areset_stall got=%0h exp=0", stall_cycles); end
        checks++; if (ALU_Control !== 6'b000000 || branch_op !== 1'b0) begin failures++; $display("FAIL areset_payload got ctrl=%0h br=%0h exp 0 0", ALU_Control, branch_op); end
        @(negedge clock);
        reset = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_forwarding();
        test_imm_and_stall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
